mdu: RTL

MDU -- requirements
Module: mdu

---
 rtl/mdu_if.sv | 16 +
 rtl/mdu.sv | 141 ++++++++++++++
 2 files changed

// File: rtl/mdu_if.sv
// rtl/mdu_if.sv - request/result bundle between a requester and the multiply/divide unit.
interface mdu_if #(
  parameter int WIDTH = 32
) ();
  logic             start;
  logic [2:0]       op;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;

  modport master (output start, op, a, b, input busy, done, hi, lo);
  modport slave  (input start, op, a, b, output busy, done, hi, lo);
endinterface

// File: rtl/mdu.sv
// rtl/mdu.sv - iterative radix-2 multiply/divide unit with HI/LO result registers.
module mdu #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 6
) (
  input  logic  clk,
  input  logic  rst,
  mdu_if.slave  bus
);
  typedef enum logic [1:0] {IDLE, RUN, FIX} state_t;

  localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

  state_t               state, state_nxt;
  logic [2*WIDTH-1:0]   acc;
  logic [WIDTH-1:0]     b_mag;
  logic [WIDTH-1:0]     a_raw;
  logic [CNT_W-1:0]     count;
  logic                 div_q;
  logic                 neg_q;
  logic                 neg_r;
  logic [WIDTH-1:0]     hi_q, lo_q;
  logic                 done_q;

  logic                 a_sign, b_sign;
  logic [WIDTH-1:0]     a_mag_c, b_mag_c;
  logic [WIDTH:0]       mul_sum;
  logic [WIDTH:0]       trial;
  logic                 ge;
  logic [WIDTH-1:0]     diff;
  logic [WIDTH-1:0]     rem_new;
  logic [2*WIDTH-1:0]   step_mul, step_div;
  logic [2*WIDTH-1:0]   prod_fix;
  logic [WIDTH-1:0]     quot_fix, rem_fix;

  // Operand magnitudes are only taken for the signed ops (op[0] set, op[2] clear).
  always_comb begin
    a_sign  = bus.op[0] & bus.a[WIDTH-1];
    b_sign  = bus.op[0] & bus.b[WIDTH-1];
    a_mag_c = a_sign ? (~bus.a + 1'b1) : bus.a;
    b_mag_c = b_sign ? (~bus.b + 1'b1) : bus.b;
  end

  // acc holds {partial product, multiplier} for multiply and {remainder, quotient} for divide.
  always_comb begin
    mul_sum  = {1'b0, acc[2*WIDTH-1:WIDTH]} + {1'b0, (acc[0] ? b_mag : '0)};
    step_mul = {mul_sum, acc[WIDTH-1:1]};
    trial    = acc[2*WIDTH-1:WIDTH-1];
    ge       = trial >= {1'b0, b_mag};
    diff     = trial[WIDTH-1:0] - b_mag;
    rem_new  = ge ? diff : trial[WIDTH-1:0];
    step_div = {rem_new, acc[WIDTH-2:0], ge};
    prod_fix = neg_q ? (~acc + 1'b1) : acc;
    quot_fix = neg_q ? (~acc[WIDTH-1:0] + 1'b1) : acc[WIDTH-1:0];
    rem_fix  = neg_r ? (~acc[2*WIDTH-1:WIDTH] + 1'b1) : acc[2*WIDTH-1:WIDTH];
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (bus.start && !bus.op[2]) state_nxt = RUN;
      RUN:     if (count == LAST) state_nxt = FIX;
      FIX:     state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      acc    <= '0;
      b_mag  <= '0;
      a_raw  <= '0;
      count  <= '0;
      div_q  <= 1'b0;
      neg_q  <= 1'b0;
      neg_r  <= 1'b0;
      hi_q   <= '0;
      lo_q   <= '0;
      done_q <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.start) begin
            case (bus.op)
              3'd0, 3'd1, 3'd2, 3'd3: begin
                acc   <= {{WIDTH{1'b0}}, a_mag_c};
                b_mag <= b_mag_c;
                a_raw <= bus.a;
                count <= '0;
                div_q <= bus.op[1];
                neg_q <= a_sign ^ b_sign;
                neg_r <= a_sign;
              end
              3'd4: begin
                hi_q   <= bus.a;
                done_q <= 1'b1;
              end
              3'd5: begin
                lo_q   <= bus.a;
                done_q <= 1'b1;
              end
              default: ;
            endcase
          end
        end
        RUN: begin
          acc   <= div_q ? step_div : step_mul;
          count <= count + 1'b1;
        end
        FIX: begin
          done_q <= 1'b1;
          if (!div_q) begin
            {hi_q, lo_q} <= prod_fix;
          end else if (b_mag == '0) begin
            // Divide by zero returns the raw dividend, bypassing sign correction.
            hi_q <= a_raw;
            lo_q <= '1;
          end else begin
            hi_q <= rem_fix;
            lo_q <= quot_fix;
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.busy = (state == RUN) || (state == FIX);
  assign bus.done = done_q;
  assign bus.hi   = hi_q;
  assign bus.lo   = lo_q;
endmodule
